// File: rtl/mc_stage_sequencer_if.sv
// Sequencer-side bundle: decode inputs, memory handshake, datapath strobes and status.
// Combinational strobes, no internal storage.
interface mc_stage_sequencer_if #(
    parameter int CW = 16
);
    logic [2:0]    opcode;
    logic          ex_done;
    logic          br_taken;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic          ir_we;
    logic          pc_we;
    logic          rf_we;
    logic [4:0]    stage;
    logic          halted;
    logic          fault;
    logic [CW-1:0] instr_count;

    modport master (
        input  opcode, ex_done, br_taken, mem_ack,
        output mem_req, mem_we, ir_we, pc_we, rf_we, stage, halted, fault, instr_count
    );

    modport slave (
        output opcode, ex_done, br_taken, mem_ack,
        input  mem_req, mem_we, ir_we, pc_we, rf_we, stage, halted, fault, instr_count
    );
endinterface

// File: rtl/mc_stage_sequencer.sv
// Multicycle CPU stage sequencer: IF/ID/EX/MEM/WB one-hot with class-based stage skipping.
// Strobes are Mealy; mem_req held until mem_ack, stalls beyond MEM_TIMEOUT cycles fault.
module mc_stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4,
    parameter int CW          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_stage_sequencer_if.master  bus
);

    typedef enum logic [6:0] {
        S_IF     = 7'b0000001,
        S_ID     = 7'b0000010,
        S_EX     = 7'b0000100,
        S_MEM    = 7'b0001000,
        S_WB     = 7'b0010000,
        S_HALTED = 7'b0100000,
        S_FAULT  = 7'b1000000
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] instr_count_q, instr_count_d;

    logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c, retire_c;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_cnt_d    = '0;
        instr_count_d = instr_count_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        ir_we_c       = 1'b0;
        pc_we_c       = 1'b0;
        rf_we_c       = 1'b0;
        retire_c      = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_ID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ID: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EX;
                    OP_HALT:                              state_d = S_HALTED;
                    default:                              state_d = S_FAULT;
                endcase
            end
            S_EX: begin
                if (bus.ex_done) begin
                    case (op_q)
                        OP_ALU:            state_d = S_WB;
                        OP_LOAD, OP_STORE: state_d = S_MEM;
                        OP_BRANCH: begin
                            pc_we_c  = bus.br_taken;
                            retire_c = 1'b1;
                            state_d  = S_IF;
                        end
                        default:           state_d = S_FAULT;
                    endcase
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op_q == OP_STORE);
                if (bus.mem_ack) begin
                    if (op_q == OP_STORE) begin
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_IF;
            end
            S_HALTED, S_FAULT: ;
            default: state_d = S_FAULT;
        endcase

        if (retire_c) begin
            instr_count_d = instr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IF;
            op_q          <= '0;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Strobes are held quiet while reset is asserted so no request escapes mid-reset.
    assign bus.mem_req     = mem_req_c & rst;
    assign bus.mem_we      = mem_we_c  & rst;
    assign bus.ir_we       = ir_we_c   & rst;
    assign bus.pc_we       = pc_we_c   & rst;
    assign bus.rf_we       = rf_we_c   & rst;
    assign bus.stage       = state_q[4:0];
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Randomized bench: per-instruction stage schedule model drives expected stage/strobes/count.
module tb_mc_stage_sequencer;

    localparam int CW  = 16;
    localparam int CWS = 3;

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [4:0] ST_IF  = 5'b00001;
    localparam logic [4:0] ST_ID  = 5'b00010;
    localparam logic [4:0] ST_EX  = 5'b00100;
    localparam logic [4:0] ST_MEM = 5'b01000;
    localparam logic [4:0] ST_WB  = 5'b10000;

    // strobe vector order {mem_req, mem_we, ir_we, pc_we, rf_we}
    localparam logic [4:0] SB_REQ = 5'b10000;
    localparam logic [4:0] SB_WE  = 5'b01000;
    localparam logic [4:0] SB_IR  = 5'b00100;
    localparam logic [4:0] SB_PC  = 5'b00010;
    localparam logic [4:0] SB_RF  = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_stage_sequencer_if #(.CW(CW))  bus();
    mc_stage_sequencer_if #(.CW(CWS)) bus_w();

    assign bus_w.opcode   = bus.opcode;
    assign bus_w.ex_done  = bus.ex_done;
    assign bus_w.br_taken = bus.br_taken;
    assign bus_w.mem_ack  = bus.mem_ack;

    mc_stage_sequencer #(.MEM_TIMEOUT(15), .TW(4), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow counter copy so the wrap-to-zero behaviour is reached quickly.
    mc_stage_sequencer #(.MEM_TIMEOUT(15), .TW(4), .CW(CWS)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned model_cnt = 0;
    logic [1:0]  model_hf = 2'b00;   // {halted, fault}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic rand_inputs();
        bus.opcode   = 3'($urandom);
        bus.ex_done  = 1'($urandom);
        bus.br_taken = 1'($urandom);
        bus.mem_ack  = 1'($urandom);
    endtask

    task automatic tick(input logic [4:0] est, input logic [4:0] estb);
        @(negedge clk);
        check("stage",   32'(bus.stage), 32'(est));
        check("strobes", 32'({bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.rf_we}), 32'(estb));
        check("count",   32'(bus.instr_count), model_cnt % 32'h10000);
        check("count_w", 32'(bus_w.instr_count), model_cnt % 32'd8);
        check("flags",   32'({bus.halted, bus.fault}), 32'(model_hf));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rand_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_cnt = 0;
        model_hf  = 2'b00;
        tick(ST_IF, 5'b0);
        rst = 1'b1;
    endtask

    task automatic terminal_cycles(input int n);
        repeat (n) begin
            rand_inputs();
            tick(5'b0, 5'b0);
        end
    endtask

    // A delay of 15 or more in IF/MEM means the ack never comes and the stage times out.
    task automatic run_instr(input logic [2:0] op, input int ifd, input int exd,
                             input int memd, input logic br);
        int n;
        n = (ifd >= 15) ? 15 : ifd + 1;
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            bus.mem_ack = (ifd < 15) && (i == ifd);
            tick(ST_IF, SB_REQ | (bus.mem_ack ? (SB_IR | SB_PC) : 5'b0));
        end
        if (ifd >= 15) begin
            model_hf = 2'b01;
            terminal_cycles(5);
            return;
        end
        rand_inputs();
        bus.opcode = op;
        tick(ST_ID, 5'b0);
        if (op == OP_HALT || op[2]) begin
            model_hf = (op == OP_HALT) ? 2'b10 : 2'b01;
            terminal_cycles(20);
            return;
        end
        for (int i = 0; i <= exd; i++) begin
            rand_inputs();
            bus.ex_done  = (i == exd);
            bus.br_taken = br;
            tick(ST_EX, (i == exd && op == OP_BRANCH && br) ? SB_PC : 5'b0);
        end
        if (op == OP_LOAD || op == OP_STORE) begin
            n = (memd >= 15) ? 15 : memd + 1;
            for (int i = 0; i < n; i++) begin
                rand_inputs();
                bus.mem_ack = (memd < 15) && (i == memd);
                tick(ST_MEM, SB_REQ | ((op == OP_STORE) ? SB_WE : 5'b0));
            end
            if (memd >= 15) begin
                model_hf = 2'b01;
                terminal_cycles(5);
                return;
            end
        end
        if (op == OP_ALU || op == OP_LOAD) begin
            rand_inputs();
            tick(ST_WB, SB_RF);
        end
        model_cnt++;
    endtask

    initial begin
        logic [2:0] op;
        int         d_if, d_ex, d_mem;
        logic [2:0] ops [4];
        ops[0] = OP_ALU; ops[1] = OP_LOAD; ops[2] = OP_STORE; ops[3] = OP_BRANCH;

        do_reset();
        run_instr(OP_ALU,    0, 0, 0, 1'b0);
        run_instr(OP_LOAD,   3, 0, 2, 1'b0);
        run_instr(OP_STORE,  0, 0, 0, 1'b0);
        run_instr(OP_BRANCH, 0, 0, 0, 1'b1);
        run_instr(OP_BRANCH, 0, 0, 0, 1'b0);
        run_instr(OP_ALU,   14, 2, 0, 1'b0);
        run_instr(OP_STORE,  0, 0, 14, 1'b0);
        run_instr(OP_ALU,   15, 0, 0, 1'b0);
        do_reset();
        run_instr(OP_LOAD,   0, 1, 15, 1'b0);
        do_reset();
        run_instr(OP_HALT,   1, 0, 0, 1'b0);
        do_reset();
        run_instr(3'b101,    0, 0, 0, 1'b0);
        do_reset();
        run_instr(3'b100,    0, 0, 0, 1'b0);
        do_reset();
        run_instr(3'b110,    2, 0, 0, 1'b0);
        do_reset();

        // Reset landing in the middle of a MEM stall after a few retirements.
        run_instr(OP_ALU,    0, 0, 0, 1'b0);
        run_instr(OP_BRANCH, 0, 0, 0, 1'b1);
        rand_inputs(); bus.mem_ack = 1'b1;
        tick(ST_IF, SB_REQ | SB_IR | SB_PC);
        rand_inputs(); bus.opcode = OP_LOAD;
        tick(ST_ID, 5'b0);
        rand_inputs(); bus.ex_done = 1'b1;
        tick(ST_EX, 5'b0);
        repeat (3) begin
            rand_inputs(); bus.mem_ack = 1'b0;
            tick(ST_MEM, SB_REQ);
        end
        do_reset();

        for (int k = 0; k < 60; k++) begin
            op    = ops[$urandom_range(0, 3)];
            d_if  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4);
            d_ex  = $urandom_range(0, 3);
            d_mem = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4);
            run_instr(op, d_if, d_ex, d_mem, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
